// File: rtl/apb_master.sv
// APB3 requester: turns a valid/ready command stream into SETUP/ACCESS transfers with one response per command.
// Optional build macro APB_TIMEOUT_EN ends ACCESS after TIMEOUT_CYCLES wait cycles with rsp_err_o set.
module apb_master #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic              cmd_write_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  state_e              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                timeout_hit;
  logic                access_done;

`ifdef APB_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_err_q, rsp_err_d;

  // A late pready_i on the final wait cycle still completes normally.
  assign timeout_hit = (state_q == ACCESS) && !pready_i && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    rsp_err_d = timeout_hit;
    if (state_q == IDLE && cmd_valid_i) begin
      tmo_cnt_d = '0;
    end else if (state_q == ACCESS && !pready_i && !timeout_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err_o   = 1'b0;
`endif

  assign access_done = (state_q == ACCESS) && (pready_i || timeout_hit);

  // NOTE: state and outputs update with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (access_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          paddr_d  = cmd_addr_i;
          pwrite_d = cmd_write_i;
          pwdata_d = cmd_wdata_i;
          psel_d   = 1'b1;
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        // prdata_i is only looked at on a real pready_i completion of a read.
        if (access_done) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (pready_i && !pwrite_q) ? prdata_i : '0;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master; a small behavioural memory stands in for the APB slave in the round-trip test.
// Build with APB_TIMEOUT_EN defined to exercise the timeout path.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [9:0]  cmd_addr_i;
  logic        cmd_write_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        psel_o;
  logic        penable_o;
  logic [9:0]  paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i;
  logic        pready_i;

  logic [31:0] prdata_drv;
  logic        use_mem;
  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_master #(.ADDR_W(10), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_write_i (cmd_write_i),
    .cmd_wdata_i (cmd_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .paddr_o     (paddr_o),
    .pwrite_o    (pwrite_o),
    .pwdata_o    (pwdata_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i)
  );

  // Behavioural slave memory used only in the round-trip test.
  assign prdata_i = use_mem ? mem[paddr_o] : prdata_drv;

  always @(posedge clk) begin
    if (use_mem && psel_o && penable_o && pwrite_o && pready_i) mem[paddr_o] <= pwdata_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command; pready_i rises on ACCESS cycle index 'waits' (never if waits < 0).
  // lat counts falling edges from the accept edge to the one where rsp_valid_o is seen.
  task automatic do_xfer(input logic [9:0] addr, input logic wr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rd_val,
                         output logic [31:0] rdata, output logic err, output int lat);
    int  guard;
    int  acc;
    logic done;
    rdata = '0;
    err   = 1'b0;
    lat   = 0;
    guard = 0;
    while (!cmd_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("xfer_ready_wait", {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = addr;
    cmd_write_i = wr;
    cmd_wdata_i = wdata;
    pready_i    = 1'b0;
    prdata_drv  = 'x;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    lat  = 1;
    acc  = 0;
    done = 1'b0;
    while (!done && lat < 100) begin
      if (rsp_valid_o) begin
        rdata = rsp_rdata_o;
        err   = rsp_err_o;
        done  = 1'b1;
      end else begin
        if (penable_o) begin
          if (acc == waits) begin
            pready_i   = 1'b1;
            prdata_drv = rd_val;
          end
          acc++;
        end
        @(negedge clk);
        lat++;
      end
    end
    pready_i   = 1'b0;
    prdata_drv = 'x;
    check("xfer_completed", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [9:0]  q_addr [3];
    logic        q_wr   [3];
    logic [31:0] q_data [3];
    logic [31:0] q_exp  [3];
    logic [9:0]  r_addr [10];
    logic [31:0] r_data [10];
    int          base;

    reset_n     = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_write_i = 1'b0;
    cmd_wdata_i = '0;
    pready_i    = 1'b0;
    prdata_drv  = '0;
    use_mem     = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_psel",      {31'd0, psel_o},      32'd0);
    check("rst_penable",   {31'd0, penable_o},   32'd0);
    check("rst_pwrite",    {31'd0, pwrite_o},    32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err_o},   32'd0);
    check("rst_paddr",     {22'd0, paddr_o},     32'd0);
    check("rst_pwdata",    pwdata_o,             32'd0);
    check("rst_rdata",     rsp_rdata_o,          32'd0);
    check("rst_ready",     {31'd0, cmd_ready_o}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Test 1: single write, zero wait states
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 10'h155;
    cmd_write_i = 1'b1;
    cmd_wdata_i = 32'h0000_ABCD;
    pready_i    = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("t1_setup_psel",    {31'd0, psel_o},      32'd1);
    check("t1_setup_penable", {31'd0, penable_o},   32'd0);
    check("t1_setup_ready",   {31'd0, cmd_ready_o}, 32'd0);
    check("t1_paddr",         {22'd0, paddr_o},     32'h155);
    check("t1_pwrite",        {31'd0, pwrite_o},    32'd1);
    check("t1_pwdata",        pwdata_o,             32'h0000_ABCD);
    @(negedge clk);
    check("t1_access_psel",    {31'd0, psel_o},      32'd1);
    check("t1_access_penable", {31'd0, penable_o},   32'd1);
    check("t1_access_rsp",     {31'd0, rsp_valid_o}, 32'd0);
    @(negedge clk);
    check("t1_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    check("t1_rsp_rdata", rsp_rdata_o,          32'd0);
    check("t1_rsp_err",   {31'd0, rsp_err_o},   32'd0);
    check("t1_done_psel", {31'd0, psel_o},      32'd0);
    check("t1_done_pen",  {31'd0, penable_o},   32'd0);
    check("t1_done_rdy",  {31'd0, cmd_ready_o}, 32'd1);
    check("t1_hold_addr", {22'd0, paddr_o},     32'h155);
    pready_i = 1'b0;
    @(negedge clk);
    check("t1_rsp_pulse", {31'd0, rsp_valid_o}, 32'd0);

    // Test 2: read with 4 wait states; prdata_i is X until the ready cycle
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 10'h3FF;
    cmd_write_i = 1'b0;
    cmd_wdata_i = 32'hDEAD_0002;
    prdata_drv  = 'x;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("t2_setup_penable", {31'd0, penable_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_penable", {31'd0, penable_o},   32'd1);
      check("t2_paddr",   {22'd0, paddr_o},     32'h3FF);
      check("t2_pwrite",  {31'd0, pwrite_o},    32'd0);
      check("t2_no_rsp",  {31'd0, rsp_valid_o}, 32'd0);
      if (i == 4) begin
        pready_i   = 1'b1;
        prdata_drv = 32'h1234_5678;
      end
    end
    @(negedge clk);
    pready_i   = 1'b0;
    prdata_drv = 'x;
    check("t2_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    check("t2_rsp_rdata", rsp_rdata_o,          32'h1234_5678);
    check("t2_rsp_err",   {31'd0, rsp_err_o},   32'd0);
    check("t2_done_pen",  {31'd0, penable_o},   32'd0);
    @(negedge clk);
    check("t2_rdata_hold", rsp_rdata_o, 32'h1234_5678);

    // Test 3: cmd_valid_i held high across three back-to-back commands
    q_addr[0] = 10'h010; q_wr[0] = 1'b0; q_data[0] = 32'h1111_1111; q_exp[0] = 32'h1111_1111;
    q_addr[1] = 10'h020; q_wr[1] = 1'b1; q_data[1] = 32'h2222_2222; q_exp[1] = 32'h0;
    q_addr[2] = 10'h030; q_wr[2] = 1'b0; q_data[2] = 32'h3333_3333; q_exp[2] = 32'h3333_3333;
    pready_i    = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = q_addr[0];
    cmd_write_i = q_wr[0];
    cmd_wdata_i = q_data[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_setup_psel",  {31'd0, psel_o},      32'd1);
      check("t3_setup_ready", {31'd0, cmd_ready_o}, 32'd0);
      check("t3_setup_addr",  {22'd0, paddr_o},     {22'd0, q_addr[i]});
      check("t3_setup_wr",    {31'd0, pwrite_o},    {31'd0, q_wr[i]});
      prdata_drv = q_data[i];
      @(negedge clk);
      check("t3_access_pen",   {31'd0, penable_o},   32'd1);
      check("t3_access_ready", {31'd0, cmd_ready_o}, 32'd0);
      @(negedge clk);
      check("t3_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("t3_rsp_rdata", rsp_rdata_o,          q_exp[i]);
      check("t3_gap_psel",  {31'd0, psel_o},      32'd0);
      check("t3_rsp_ready", {31'd0, cmd_ready_o}, 32'd1);
      if (i < 2) begin
        cmd_addr_i  = q_addr[i+1];
        cmd_write_i = q_wr[i+1];
        cmd_wdata_i = q_data[i+1];
      end else begin
        cmd_valid_i = 1'b0;
      end
    end
    pready_i = 1'b0;
    @(negedge clk);
    check("t3_idle_psel", {31'd0, psel_o},      32'd0);
    check("t3_idle_rsp",  {31'd0, rsp_valid_o}, 32'd0);

    // Test 4: reset asserted during ACCESS of a write
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 10'h0AA;
    cmd_write_i = 1'b1;
    cmd_wdata_i = 32'h5555_AAAA;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    check("t4_in_access", {31'd0, penable_o}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t4_async_psel", {31'd0, psel_o},    32'd0);
    check("t4_async_pen",  {31'd0, penable_o}, 32'd0);
    @(negedge clk);
    check("t4_no_rsp",    {31'd0, rsp_valid_o}, 32'd0);
    check("t4_rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("t4_rst_paddr", {22'd0, paddr_o},     32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("t4_still_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    do_xfer(10'h0AB, 1'b0, 32'h0, 0, 32'hCAFE_F00D, rd, er, lat);
    check("t4_after_rdata", rd,               32'hCAFE_F00D);
    check("t4_after_err",   {31'd0, er},      32'd0);
    check("t4_after_lat",   lat,              32'd3);

`ifdef APB_TIMEOUT_EN
    // Test 5: pready_i stuck low times out after 16 ACCESS cycles
    do_xfer(10'h101, 1'b0, 32'h0, -1, 32'h0, rd, er, lat);
    check("t5_tmo_err",   {31'd0, er}, 32'd1);
    check("t5_tmo_rdata", rd,          32'd0);
    check("t5_tmo_lat",   lat,         32'd18);
    check("t5_tmo_psel",  {31'd0, psel_o}, 32'd0);
    // pready_i on the 16th ACCESS cycle wins over the timeout
    do_xfer(10'h102, 1'b0, 32'h0, 15, 32'h0BAD_BEEF, rd, er, lat);
    check("t5_late_err",   {31'd0, er}, 32'd0);
    check("t5_late_rdata", rd,          32'h0BAD_BEEF);
    check("t5_late_lat",   lat,         32'd18);
    do_xfer(10'h103, 1'b0, 32'h0, 14, 32'h7777_0000, rd, er, lat);
    check("t5_15w_err", {31'd0, er}, 32'd0);
    check("t5_15w_lat", lat,         32'd17);
`else
    // Test 5 (feature disabled): a long stall just waits, never flags an error
    do_xfer(10'h101, 1'b0, 32'h0, 30, 32'h0BAD_BEEF, rd, er, lat);
    check("t5_nto_err",   {31'd0, er}, 32'd0);
    check("t5_nto_rdata", rd,          32'h0BAD_BEEF);
    check("t5_nto_lat",   lat,         32'd33);
`endif

    // Test 6: round trip through a behavioural slave memory
    use_mem = 1'b1;
    base    = int'($urandom_range(0, 1023));
    for (int i = 0; i < 10; i++) begin
      r_addr[i] = 10'((base + i * 101) % 1024);
      r_data[i] = $urandom;
      do_xfer(r_addr[i], 1'b1, r_data[i], int'($urandom_range(0, 2)), 32'h0, rd, er, lat);
      check("t6_wr_rdata", rd, 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      do_xfer(r_addr[i], 1'b0, 32'h0, int'($urandom_range(0, 2)), 32'h0, rd, er, lat);
      check("t6_rd_data", rd,          r_data[i]);
      check("t6_rd_err",  {31'd0, er}, 32'd0);
    end
    use_mem = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Upstream APB requester that drives the team's `apb_slave`.
- Converts a simple valid/ready command stream into compliant APB3 SETUP/ACCESS transfers.
- Returns one response per command (read data, optional error flag).
- Replaces hand-driven psel/penable sequencing in benches, and is the bus-side front end for future register-block integration.

Parameters:
- ADDR_W, 10, APB address width (matches slave paddr_i).
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 16, max ACCESS wait cycles with pready low (used only with APB_TIMEOUT_EN); must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  master can accept a command.
- cmd_addr_i  in  ADDR_W  command address.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_wdata_i  in  DATA_W  write data.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  DATA_W  read data (0 for writes).
- rsp_err_o  out  1  transfer timed out (feature only; else 0).
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- paddr_o  out  ADDR_W  APB address.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  DATA_W  APB write data.
- prdata_i  in  DATA_W  APB read data.
- pready_i  in  1  APB ready.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o = 0.
  - paddr_o, pwdata_o, rsp_rdata_o = 0.
  - Timeout counter = 0.
- All APB and rsp outputs are registered. cmd_ready_o = (state == IDLE), decoded from state.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE: on an edge with cmd_valid_i & cmd_ready_o, capture addr/write/wdata into paddr_o/pwrite_o/pwdata_o, set psel_o = 1, go to SETUP.
  - SETUP: next edge sets penable_o = 1, go to ACCESS. This is unconditionally one cycle.
  - ACCESS: on an edge with pready_i = 1, clear psel_o and penable_o, pulse rsp_valid_o = 1 for exactly one cycle, go to IDLE. rsp_rdata_o = prdata_i for reads, 0 for writes; rsp_err_o = 0.
  - ACCESS with pready_i = 0: hold all APB outputs stable.
- Latency: response pulse is minimum 3 edges after the accept edge (SETUP, ACCESS, completion); +1 per wait-state cycle.
- Back-to-back commands:
  - At least one IDLE cycle between transfers.
  - cmd_ready_o is high in the same cycle rsp_valid_o is high, so the next command may be accepted then.
  - psel_o returns low for at least one cycle between transfers.
- paddr_o, pwrite_o, pwdata_o:
  - Stable from SETUP through completion.
  - Retain their last value in IDLE.
  - pwdata_o is loaded for reads too (don't-care on bus).
- cmd_* inputs are ignored outside IDLE; cmd_valid_i may stay high without being consumed.
- rsp_rdata_o holds its value until the next response.
- Reset mid-transfer: psel_o and penable_o drop immediately (async), the in-flight command is dropped, and no response is issued.
- X-safety: pready_i and prdata_i are sampled only in ACCESS.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - Counter increments on each ACCESS cycle with pready_i = 0.
  - When the count reaches TIMEOUT_CYCLES-1 and pready_i is still 0, the next edge ends the transfer: psel_o/penable_o = 0, rsp_valid_o = 1, rsp_err_o = 1, rsp_rdata_o = 0, state IDLE.
  - pready_i arriving on that same edge wins: normal completion, err = 0.
  - Counter clears on entering SETUP.
- Not defined:
  - ACCESS waits indefinitely.
  - rsp_err_o is tied to 0.
  - No counter logic is synthesized.

Test Plan:
1. Write addr 0x155, data 0x0000ABCD, pready_i tied 1:
   - psel_o high 2 cycles, penable_o high 1 cycle.
   - rsp_valid_o pulses 3 edges after accept, rsp_rdata_o = 0.
2. Read addr 0x3FF, slave holds pready_i low 4 ACCESS cycles then returns 0x12345678:
   - penable_o high 5 cycles, paddr_o stable throughout.
   - rsp_rdata_o = 0x12345678, rsp_err_o = 0.
3. cmd_valid_i held high with 3 queued commands:
   - cmd_ready_o low in SETUP/ACCESS.
   - Each command accepted in the rsp_valid_o cycle.
   - psel_o low exactly 1 cycle between transfers; 3 responses in order.
4. Assert reset_n low during ACCESS of a write:
   - psel_o/penable_o = 0 before the next edge, no rsp_valid_o.
   - After release, the next command completes normally.
5. With APB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, pready_i stuck 0:
   - rsp_valid_o with rsp_err_o = 1 after 16 ACCESS cycles.
   - Repeat with pready_i rising on cycle 16: err = 0.
6. Paired with `apb_slave`: 10 writes to random addresses/data, then 10 reads of the same addresses -> every rsp_rdata_o equals the written data.
